neuron_param_loader: RTL and testbench

NEURON_PARAM_LOADER -- requirements
Module: neuron_param_loader

---
 rtl/neuron_param_loader.sv | 174 +++++++++++++++++
 tb/tb_neuron_param_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_param_loader.sv
// Streams three parameter words per neuron into a Wishbone-mapped parameter
// memory, optionally reading each word back to verify it.
module neuron_param_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter logic [31:0] NEURON_STRIDE  = 32'h0000_0010,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        verify_i,
  input  logic [7:0]  neuron_count_i,
  input  logic [31:0] param_dat_i,
  input  logic        param_valid_i,
  output logic        param_ready_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_code_o,
  output logic [7:0]  neuron_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WRITE, S_GAP_W, S_READ, S_GAP_R, S_FINISH, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        verify_q, verify_d;
  logic [1:0]  word_q, word_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdat_q, rdat_d;
  logic [31:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic [31:0] addr;
  logic [31:0] cmp_mask;
  logic        mismatch;
  logic        tmo_last;
  logic        last_word;
  logic        last_neuron;
  logic        in_xfer;

  assign addr        = BASE_ADDR + 32'(idx_q) * NEURON_STRIDE + 32'(word_q) * 32'd4;
  // Word 0 bits [7:0] hold the live membrane potential, which may change underneath us.
  assign cmp_mask    = (word_q == 2'd0) ? 32'hFFFF_FF00 : '1;
  assign mismatch    = |((rdat_q ^ dat_q) & cmp_mask);
  assign tmo_last    = (tmo_q == 32'(TIMEOUT_CYCLES - 1));
  assign last_word   = (word_q == 2'd2);
  assign last_neuron = ({1'b0, idx_q} + 9'd1) == {1'b0, cnt_q};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      verify_q <= 1'b0;
      word_q   <= '0;
      idx_q    <= '0;
      dat_q    <= '0;
      rdat_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      verify_q <= verify_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      dat_q    <= dat_d;
      rdat_q   <= rdat_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    verify_d = verify_q;
    word_d   = word_q;
    idx_d    = idx_q;
    dat_d    = dat_q;
    rdat_d   = rdat_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    code_d   = code_q;

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cnt_d    = neuron_count_i;
            verify_d = verify_i;
            err_d    = 1'b0;
            code_d   = '0;
            word_d   = '0;
            idx_d    = '0;
            state_d  = (neuron_count_i == 8'd0) ? S_FINISH : S_FETCH;
          end
        end
        S_FETCH: begin
          if (param_valid_i) begin
            dat_d   = param_dat_i;
            tmo_d   = '0;
            state_d = S_WRITE;
          end
        end
        S_WRITE, S_READ: begin
          if (wbm_ack_i) begin
            if (state_q == S_READ) rdat_d = wbm_dat_i;
            state_d = (state_q == S_READ) ? S_GAP_R : S_GAP_W;
          end else if (tmo_last) begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = S_ERROR;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
        S_GAP_W, S_GAP_R: begin
          if (state_q == S_GAP_W && verify_q) begin
            tmo_d   = '0;
            state_d = S_READ;
          end else if (state_q == S_GAP_R && mismatch) begin
            err_d   = 1'b1;
            code_d  = 2'b10;
            state_d = S_ERROR;
          end else if (last_word) begin
            word_d  = '0;
            idx_d   = idx_q + 8'd1;
            state_d = last_neuron ? S_FINISH : S_FETCH;
          end else begin
            word_d  = word_q + 2'd1;
            state_d = S_FETCH;
          end
        end
        S_FINISH: state_d = S_IDLE;
        S_ERROR:  state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  assign in_xfer       = (state_q == S_WRITE) || (state_q == S_READ);
  assign wbm_cyc_o     = in_xfer;
  assign wbm_stb_o     = in_xfer;
  assign wbm_we_o      = (state_q == S_WRITE);
  assign wbm_sel_o     = in_xfer ? 4'hF : 4'h0;
  assign wbm_adr_o     = in_xfer ? addr : '0;
  assign wbm_dat_o     = dat_q;
  assign param_ready_o = (state_q == S_FETCH);
  assign busy_o        = (state_q == S_FETCH) || in_xfer ||
                         (state_q == S_GAP_W) || (state_q == S_GAP_R);
  assign done_o        = (state_q == S_FINISH);
  assign error_o       = err_q;
  assign err_code_o    = code_q;
  assign neuron_idx_o  = idx_q;

endmodule

// File: tb/tb_neuron_param_loader.sv
// Directed bench for neuron_param_loader: a Wishbone responder with memory,
// a parameter stream source, and a transfer-list model checked every cycle.
module tb_neuron_param_loader;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] STRIDE = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        start_i = 1'b0, abort_i = 1'b0, verify_i = 1'b0;
  logic [7:0]  neuron_count_i = '0;
  logic [31:0] param_dat_i;
  logic        param_valid_i, param_ready_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy_o, done_o, error_o;
  logic [1:0]  err_code_o;
  logic [7:0]  neuron_idx_o;

  neuron_param_loader #(.BASE_ADDR(BASE), .NEURON_STRIDE(STRIDE), .TIMEOUT_CYCLES(255)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start_i(start_i), .abort_i(abort_i),
    .verify_i(verify_i), .neuron_count_i(neuron_count_i), .param_dat_i(param_dat_i),
    .param_valid_i(param_valid_i), .param_ready_o(param_ready_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .err_code_o(err_code_o), .neuron_idx_o(neuron_idx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
  } xfer_t;

  int          n_chk = 0, n_fail = 0;
  xfer_t       exp_q[$];
  logic [31:0] src_q[$];
  logic [31:0] mem [logic [31:0]];
  bit          noack = 1'b0;
  int          lat = 0;
  logic [31:0] corrupt_adr = '1, corrupt_mask = '0;
  int          done_cnt = 0;
  int          run_len = 0, last_cyc_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Expected bus transfers and outcome, derived from the load rules alone.
  task automatic build_model(input int cnt, input bit ver, input logic [31:0] words[$],
                             output logic [1:0] code, output int eidx);
    logic [31:0] a, diff;
    exp_q.delete();
    code = 2'b00;
    eidx = 0;
    if (noack) begin
      if (cnt != 0) code = 2'b01;
      return;
    end
    for (int n = 0; n < cnt; n++) begin
      for (int w = 0; w < 3; w++) begin
        a = BASE + 32'(n) * STRIDE + 32'(w) * 32'd4;
        exp_q.push_back('{we: 1'b1, adr: a, dat: words[n*3+w]});
        if (ver) begin
          exp_q.push_back('{we: 1'b0, adr: a, dat: 32'h0});
          diff = (a == corrupt_adr) ? corrupt_mask : 32'h0;
          if (w == 0) diff = diff & 32'hFFFF_FF00;
          if (diff != 0) begin
            code = 2'b10;
            eidx = n;
            return;
          end
        end
      end
    end
  endtask

  // Parameter stream source
  initial begin
    bit will;
    param_valid_i = 1'b0;
    param_dat_i   = '0;
    forever begin
      @(negedge clk);
      will = param_valid_i && param_ready_o;
      @(posedge clk);
      #1;
      if (will && src_q.size() > 0) void'(src_q.pop_front());
      param_valid_i = (src_q.size() > 0) && !wb_rst_i;
      param_dat_i   = (src_q.size() > 0) ? src_q[0] : 32'h0;
    end
  end

  // Wishbone responder: registered ack, held while cyc&stb stay high
  initial begin
    bit          r_req, r_we;
    logic [31:0] r_adr, r_dat;
    int          wcnt;
    wcnt = 0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      r_req = wbm_cyc_o && wbm_stb_o;
      r_we  = wbm_we_o;
      r_adr = wbm_adr_o;
      r_dat = wbm_dat_o;
      @(posedge clk);
      #1;
      if (!r_req || noack || wb_rst_i) begin
        wbm_ack_i = 1'b0;
        wcnt = 0;
      end else if (!wbm_ack_i) begin
        if (wcnt >= lat) begin
          wbm_ack_i = 1'b1;
          if (r_we) mem[r_adr] = r_dat;
          else wbm_dat_i = rd_mem(r_adr) ^ ((r_adr == corrupt_adr) ? corrupt_mask : 32'h0);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Per-cycle compare against the expected transfer list and bus rules
  initial begin
    bit          p_cyc, p_xfer, p_done, p_we;
    logic [31:0] p_adr, p_dat;
    xfer_t       e;
    p_cyc = 0; p_xfer = 0; p_done = 0; p_we = 0; p_adr = '0; p_dat = '0;
    forever begin
      @(negedge clk);
      if (wb_rst_i) begin
        p_cyc = 0; p_xfer = 0; p_done = 0; run_len = 0;
      end else begin
        if (wbm_cyc_o) begin
          chk("sel during transfer", 32'(wbm_sel_o), 32'hF);
          chk("stb follows cyc", 32'(wbm_stb_o), 32'h1);
          chk("busy during transfer", 32'(busy_o), 32'h1);
        end
        if (param_ready_o) chk("ready excludes cyc", 32'(wbm_cyc_o), 32'h0);
        if (p_xfer) chk("idle cycle after ack", 32'(wbm_cyc_o), 32'h0);
        if (p_cyc && !p_xfer && wbm_cyc_o) begin
          chk("hold adr", wbm_adr_o, p_adr);
          chk("hold we", 32'(wbm_we_o), 32'(p_we));
          chk("hold dat", wbm_dat_o, p_dat);
        end
        p_xfer = wbm_cyc_o && wbm_stb_o && wbm_ack_i;
        if (p_xfer) begin
          chk("transfer expected", 32'(exp_q.size() != 0), 32'h1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("xfer we", 32'(wbm_we_o), 32'(e.we));
            chk("xfer adr", wbm_adr_o, e.adr);
            if (e.we) chk("xfer dat", wbm_dat_o, e.dat);
          end
        end
        if (done_o) begin
          done_cnt++;
          chk("done single cycle", 32'(p_done), 32'h0);
          chk("done not busy", 32'(busy_o), 32'h0);
        end
        if (wbm_cyc_o) run_len++;
        else if (p_cyc) begin
          last_cyc_len = run_len;
          run_len = 0;
        end
        p_cyc = wbm_cyc_o; p_done = done_o; p_we = wbm_we_o;
        p_adr = wbm_adr_o; p_dat = wbm_dat_o;
      end
    end
  end

  task automatic run(input int cnt, input bit ver, input logic [31:0] words[$],
                     input int restart_at, input string tag);
    logic [1:0] ecode;
    int         eidx, d0;
    bit         got;
    build_model(cnt, ver, words, ecode, eidx);
    src_q = words;
    d0 = done_cnt;
    @(negedge clk);
    neuron_count_i = 8'(cnt);
    verify_i = ver;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    if (cnt == 0) chk({tag, " done one cycle after start"}, 32'(done_o), 32'h1);
    got = 0;
    for (int i = 0; i < 5000; i++) begin
      if (done_o || error_o) begin
        got = 1;
        break;
      end
      if (i == restart_at) begin
        start_i = 1'b1;
        neuron_count_i = 8'd5;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    chk({tag, " completes"}, 32'(got), 32'h1);
    chk({tag, " error_o"}, 32'(error_o), 32'(ecode != 2'b00));
    chk({tag, " err_code_o"}, 32'(err_code_o), 32'(ecode));
    if (ecode == 2'b10) chk({tag, " neuron_idx_o"}, 32'(neuron_idx_o), 32'(eidx));
    chk({tag, " busy_o at end"}, 32'(busy_o), 32'h0);
    repeat (3) @(negedge clk);
    chk({tag, " done pulses"}, 32'(done_cnt - d0), (ecode == 2'b00) ? 32'h1 : 32'h0);
    chk({tag, " transfers left"}, 32'(exp_q.size()), 32'h0);
    src_q.delete();
  endtask

  task automatic stall_in_write(input string tag);
    src_q = '{32'hDEAD_BEEF};
    exp_q.delete();
    noack = 1'b1;
    @(negedge clk);
    neuron_count_i = 8'd1;
    verify_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(negedge clk);
    chk({tag, " in write"}, 32'(wbm_cyc_o & wbm_we_o), 32'h1);
    chk({tag, " stream stalled"}, 32'(param_valid_i), 32'h0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " cyc"}, 32'(wbm_cyc_o), 32'h0);
    chk({tag, " stb"}, 32'(wbm_stb_o), 32'h0);
    chk({tag, " we/sel"}, 32'({wbm_we_o, wbm_sel_o}), 32'h0);
    chk({tag, " adr"}, wbm_adr_o, 32'h0);
    chk({tag, " dat"}, wbm_dat_o, 32'h0);
    chk({tag, " ready/busy/done"}, 32'({param_ready_o, busy_o, done_o}), 32'h0);
    chk({tag, " error/code"}, 32'({error_o, err_code_o}), 32'h0);
    chk({tag, " neuron_idx"}, 32'(neuron_idx_o), 32'h0);
  endtask

  initial begin
    int   d0;
    logic e0;
    #2 wb_rst_i = 1'b1;
    @(negedge clk);
    chk_outputs_zero("reset");
    @(negedge clk);
    wb_rst_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("no bus activity before start", 32'(wbm_cyc_o | busy_o), 32'h0);

    lat = 0;
    run(1, 1'b0, '{32'h1122_3344, 32'h5566_7788, 32'h000A_0B0C}, -1, "single");
    chk("mem 40000000", rd_mem(32'h4000_0000), 32'h1122_3344);
    chk("mem 40000004", rd_mem(32'h4000_0004), 32'h5566_7788);
    chk("mem 40000008", rd_mem(32'h4000_0008), 32'h000A_0B0C);

    lat = 1;
    run(2, 1'b1, '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                   32'hB000_0001, 32'hB000_0002, 32'hB000_0003}, 3, "verify2");
    chk("mem 40000010", rd_mem(32'h4000_0010), 32'hB000_0001);
    chk("mem 40000018", rd_mem(32'h4000_0018), 32'hB000_0003);
    chk("verify2 neuron_idx", 32'(neuron_idx_o), 32'h2);

    lat = 0;
    corrupt_adr = 32'h4000_0000;
    corrupt_mask = 32'h0000_00A5;
    run(1, 1'b1, '{32'hC1C2_C3C4, 32'hC5C6_C7C8, 32'hC9CA_CBCC}, -1, "potential");
    chk("potential no error", 32'(error_o), 32'h0);

    corrupt_adr = 32'h4000_0004;
    corrupt_mask = 32'h0000_0001;
    run(2, 1'b1, '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303,
                   32'h0404_0404, 32'h0505_0505, 32'h0606_0606}, -1, "mismatch");
    chk("mismatch code literal", 32'({error_o, err_code_o}), 32'h6);
    corrupt_adr = '1;
    corrupt_mask = '0;

    noack = 1'b1;
    run(1, 1'b0, '{32'h7777_0000, 32'h7777_0001, 32'h7777_0002}, -1, "timeout");
    chk("timeout cyc length", 32'(last_cyc_len), 32'd255);
    chk("timeout code literal", 32'({error_o, err_code_o}), 32'h5);
    noack = 1'b0;

    run(0, 1'b0, '{}, -1, "zero");
    chk("zero clears error", 32'(error_o), 32'h0);

    lat = 2;
    run(3, 1'b0, '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9}, -1, "three");
    chk("mem 40000028", rd_mem(32'h4000_0028), 32'h9);
    lat = 0;

    stall_in_write("abort");
    d0 = done_cnt;
    e0 = error_o;
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort cyc/stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'h0);
    chk("abort ready/busy", 32'({param_ready_o, busy_o}), 32'h0);
    chk("abort error_o unchanged", 32'(error_o), 32'(e0));
    repeat (3) @(negedge clk);
    chk("abort no done", 32'(done_cnt - d0), 32'h0);
    chk("abort stays idle", 32'(wbm_cyc_o | busy_o), 32'h0);

    stall_in_write("rst");
    d0 = done_cnt;
    #2 wb_rst_i = 1'b1;
    #1;
    chk_outputs_zero("async reset");
    @(negedge clk);
    wb_rst_i = 1'b0;
    noack = 1'b0;
    src_q.delete();
    repeat (4) @(negedge clk);
    chk("post-reset idle", 32'(wbm_cyc_o | busy_o), 32'h0);
    chk("reset no done", 32'(done_cnt - d0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

endmodule
